// File: rtl/psum_acc_pkg.sv
// Shared constants, write-mode encoding and lane arithmetic for the psum accumulation buffer.
// The saturating add runs on a wide signed carrier so that one function serves every lane width.
package psum_acc_pkg;

    localparam int COL_DEFAULT     = 8;
    localparam int BW_PSUM_DEFAULT = 20;
    localparam int DEPTH_DEFAULT   = 16;

    // Carrier width for lane arithmetic; lanes up to SAT_W-2 bits add without wrapping.
    localparam int SAT_W = 64;

    typedef enum logic {
        WR_OVERWRITE = 1'b0,
        WR_ACCUM     = 1'b1
    } wr_mode_e;

    typedef logic signed [SAT_W-1:0] sat_t;

    function automatic int lane_lo(input int lane, input int bw);
        return lane * bw;
    endfunction

    // Signed add of two sign-extended w-bit values, clamped to the w-bit signed range.
    function automatic sat_t sat_add(input sat_t a, input sat_t b, input int w);
        sat_t sum;
        sat_t hi;
        sat_t lo;
        sat_t res;
        sum = a + b;
        hi  = (sat_t'(1) <<< (w - 1)) - sat_t'(1);
        lo  = -hi - sat_t'(1);
        if (sum > hi) begin
            res = hi;
        end else if (sum < lo) begin
            res = lo;
        end else begin
            res = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/psum_acc_buf_lane.sv
// One psum lane of the commit datapath: mask, overwrite or saturating accumulate, and the
// per-lane clamp flag. Purely combinational; the top module registers around it.
module psum_lane_add
    import psum_acc_pkg::*;
#(
    parameter int bw = BW_PSUM_DEFAULT
) (
    input  logic [bw-1:0] old_i,
    input  logic [bw-1:0] add_i,
    input  logic          acc_i,
    input  logic          mask_i,
    output logic [bw-1:0] new_o,
    output logic          ovf_o
);

    sat_t     old_ext;
    sat_t     add_ext;
    sat_t     raw_sum;
    sat_t     clamped;
    wr_mode_e mode;

    always_comb begin
        old_ext = sat_t'($signed(old_i));
        add_ext = sat_t'($signed(add_i));
        raw_sum = old_ext + add_ext;
        clamped = sat_add(old_ext, add_ext, bw);
        mode    = wr_mode_e'(acc_i);
        new_o   = old_i;
        ovf_o   = 1'b0;
        if (mask_i) begin
            case (mode)
                WR_ACCUM: begin
                    new_o = clamped[bw-1:0];
                    ovf_o = (clamped != raw_sum);
                end
                default: begin
                    new_o = add_i;
                end
            endcase
        end
    end

endmodule

// File: rtl/psum_acc_buf.sv
// Partial-sum row buffer: two-stage masked overwrite/accumulate writes with forwarding,
// write-through reads with optional clear, and a registered sign-extended row sum.
module psum_acc_buf
    import psum_acc_pkg::*;
#(
    parameter  int col     = COL_DEFAULT,
    parameter  int bw_psum = BW_PSUM_DEFAULT,
    parameter  int depth   = DEPTH_DEFAULT,
    localparam int addr_w  = $clog2(depth),
    localparam int row_w   = col * bw_psum,
    localparam int sum_w   = bw_psum + $clog2(col)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic                    wr_acc,
    input  logic [col-1:0]          wr_mask,
    input  logic [addr_w-1:0]       wr_addr,
    input  logic [row_w-1:0]        wr_data,
    input  logic                    rd_en,
    input  logic                    rd_clr,
    input  logic [addr_w-1:0]       rd_addr,
    output logic [row_w-1:0]        rd_data,
    output logic                    rd_valid,
    output logic signed [sum_w-1:0] sum_out,
    output logic                    ovf,
    output logic                    rd_conflict
);

    logic [row_w-1:0]        mem_q [depth];

    logic                    s1_valid_q;
    logic                    s1_acc_q;
    logic [col-1:0]          s1_mask_q;
    logic [addr_w-1:0]       s1_addr_q;
    logic [row_w-1:0]        s1_data_q;
    logic [row_w-1:0]        s1_old_q;
    logic [row_w-1:0]        s1_old_d;

    logic [row_w-1:0]        commit_row;
    logic [col-1:0]          lane_ovf;

    logic [row_w-1:0]        rd_data_q;
    logic [row_w-1:0]        rd_data_d;
    logic                    rd_valid_q;
    logic signed [sum_w-1:0] sum_q;
    logic signed [sum_w-1:0] sum_d;
    logic                    ovf_q;
    logic                    rd_conflict_q;

    logic                    commit_hit_rd;
    logic                    clr_take;
    logic                    clr_conflict;
    logic                    fwd_commit;
    logic                    fwd_zero;

    for (genvar gi = 0; gi < col; gi++) begin : g_lane
        psum_lane_add #(
            .bw (bw_psum)
        ) u_lane (
            .old_i  (s1_old_q[lane_lo(gi, bw_psum) +: bw_psum]),
            .add_i  (s1_data_q[lane_lo(gi, bw_psum) +: bw_psum]),
            .acc_i  (s1_acc_q),
            .mask_i (s1_mask_q[gi]),
            .new_o  (commit_row[lane_lo(gi, bw_psum) +: bw_psum]),
            .ovf_o  (lane_ovf[gi])
        );
    end

    // A commit landing on the row being read-cleared at the same edge wins over the clear.
    always_comb begin
        commit_hit_rd = s1_valid_q && (s1_addr_q == rd_addr);
        clr_take      = rd_en && rd_clr && !commit_hit_rd;
        clr_conflict  = rd_en && rd_clr && commit_hit_rd;
        fwd_commit    = s1_valid_q && (s1_addr_q == wr_addr);
        fwd_zero      = clr_take && (rd_addr == wr_addr);
    end

    always_comb begin
        s1_old_d = mem_q[wr_addr];
        if (fwd_commit) begin
            s1_old_d = commit_row;
        end else if (fwd_zero) begin
            s1_old_d = '0;
        end
    end

    always_comb begin
        rd_data_d = commit_hit_rd ? commit_row : mem_q[rd_addr];
        sum_d     = '0;
        for (int i = 0; i < col; i++) begin
            sum_d = sum_d + sum_w'($signed(rd_data_d[i*bw_psum +: bw_psum]));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (clr_take) begin
                mem_q[rd_addr] <= '0;
            end
            if (s1_valid_q) begin
                mem_q[s1_addr_q] <= commit_row;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_acc_q   <= 1'b0;
            s1_mask_q  <= '0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            s1_old_q   <= '0;
        end else begin
            s1_valid_q <= wr_en;
            if (wr_en) begin
                s1_acc_q  <= wr_acc;
                s1_mask_q <= wr_mask;
                s1_addr_q <= wr_addr;
                s1_data_q <= wr_data;
                s1_old_q  <= s1_old_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            sum_q         <= '0;
            ovf_q         <= 1'b0;
            rd_conflict_q <= 1'b0;
        end else begin
            rd_valid_q    <= rd_en;
            ovf_q         <= s1_valid_q && (|lane_ovf);
            rd_conflict_q <= clr_conflict;
            if (rd_en) begin
                rd_data_q <= rd_data_d;
                sum_q     <= sum_d;
            end
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign sum_out     = sum_q;
    assign ovf         = ovf_q;
    assign rd_conflict = rd_conflict_q;

endmodule

// File: tb/tb_psum_acc_buf.sv
// Directed bench for psum_acc_buf: overwrite, accumulate, saturation, masking, forwarding,
// read-clear conflicts and row-sum sign extension, against hand-computed values.
module tb_psum_acc_buf;

    localparam int COL = 8;
    localparam int BW  = 20;
    localparam int AW  = 4;
    localparam int RW  = COL * BW;
    localparam int SW  = BW + 3;

    logic                 clk;
    logic                 reset;
    logic                 wr_en;
    logic                 wr_acc;
    logic [COL-1:0]       wr_mask;
    logic [AW-1:0]        wr_addr;
    logic [RW-1:0]        wr_data;
    logic                 rd_en;
    logic                 rd_clr;
    logic [AW-1:0]        rd_addr;
    logic [RW-1:0]        rd_data;
    logic                 rd_valid;
    logic signed [SW-1:0] sum_out;
    logic                 ovf;
    logic                 rd_conflict;

    int n_checks = 0;
    int n_fail   = 0;

    psum_acc_buf u_dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_acc      (wr_acc),
        .wr_mask     (wr_mask),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_clr      (rd_clr),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .sum_out     (sum_out),
        .ovf         (ovf),
        .rd_conflict (rd_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [RW-1:0] got,
                         input logic signed [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] row_all(input int v);
        logic [RW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(v);
        return r;
    endfunction

    function automatic logic signed [BW-1:0] lane_of(input logic [RW-1:0] r, input int i);
        return r[i*BW +: BW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [AW-1:0] a, input logic acc, input logic [COL-1:0] m,
                          input logic [RW-1:0] d);
        wr_en = 1'b1; wr_acc = acc; wr_mask = m; wr_addr = a; wr_data = d;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; rd_clr = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic clr);
        rd_en = 1'b1; rd_clr = clr; rd_addr = a;
        tick();
        idle();
        $display("read row %0d clr=%0d -> valid=%0d sum=%0d conflict=%0d",
                 a, clr, rd_valid, sum_out, rd_conflict);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic acc, input logic [COL-1:0] m,
                            input logic [RW-1:0] d);
        set_wr(a, acc, m, d);
        tick();
        wr_en = 1'b0;
        $display("write row %0d acc=%0d mask=%02h", a, acc, m);
    endtask

    logic [RW-1:0] mix_row;

    initial begin
        reset = 1'b0; wr_acc = 1'b0; wr_mask = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        idle();
        repeat (3) tick();
        check("reset_rd_valid", RW'(rd_valid), 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_sum", RW'(sum_out), 0);
        check("reset_ovf", RW'(ovf), 0);
        check("reset_conflict", RW'(rd_conflict), 0);
        reset = 1'b1;

        // Row 0 after reset
        do_read(0, 1'b0);
        check("row0_valid", RW'(rd_valid), 1);
        check("row0_data", rd_data, 0);
        check("row0_sum", RW'(sum_out), 0);
        tick();
        check("row0_valid_drop", RW'(rd_valid), 0);

        // Reset while a write to row 3 sits in S1
        do_write(3, 1'b0, 8'hFF, row_all(77));
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        do_read(3, 1'b0);
        check("row3_dropped", rd_data, 0);

        // Overwrite then three back-to-back accumulates on row 5
        set_wr(5, 1'b0, 8'hFF, row_all(100));
        tick();
        for (int k = 0; k < 3; k++) begin
            set_wr(5, 1'b1, 8'hFF, row_all(20));
            tick();
            check("row5_ovf_quiet", RW'(ovf), 0);
        end
        idle();
        tick();
        check("row5_ovf_quiet_last", RW'(ovf), 0);
        do_read(5, 1'b0);
        check("row5_data", rd_data, row_all(160));
        check("row5_sum", RW'(sum_out), 1280);
        check("row5_hold_ovf", RW'(ovf), 0);

        // rd_clr without rd_en must not touch the row
        rd_clr = 1'b1; rd_addr = 5;
        tick();
        idle();
        check("row5_hold_data", rd_data, row_all(160));
        do_read(5, 1'b0);
        check("row5_not_cleared", rd_data, row_all(160));

        // Positive saturation on masked lanes 0-3; lanes 4-7 carry -5 but are masked off
        set_wr(2, 1'b0, 8'hFF, row_all(524287));
        tick();
        mix_row = row_all(1);
        for (int i = 4; i < COL; i++) mix_row[i*BW +: BW] = BW'(-5);
        set_wr(2, 1'b1, 8'h0F, mix_row);
        tick();
        check("row2_ovf_overwrite", RW'(ovf), 0);
        idle();
        tick();
        check("row2_ovf_pos", RW'(ovf), 1);
        tick();
        check("row2_ovf_pulse", RW'(ovf), 0);
        do_read(2, 1'b0);
        check("row2_sat_pos", rd_data, row_all(524287));

        // Negative saturation on lane 0
        set_wr(2, 1'b0, 8'h01, row_all(-524288));
        tick();
        set_wr(2, 1'b1, 8'h01, row_all(-1));
        tick();
        idle();
        tick();
        check("row2_ovf_neg", RW'(ovf), 1);
        do_read(2, 1'b0);
        check("row2_lane0_neg", RW'(lane_of(rd_data, 0)), -524288);
        check("row2_lane1_kept", RW'(lane_of(rd_data, 1)), 524287);

        // Read-clear of row 7 lands on the accumulate commit: commit wins
        do_write(7, 1'b0, 8'hFF, row_all(10));
        tick();
        do_write(7, 1'b1, 8'hFF, row_all(3));
        do_read(7, 1'b1);
        check("row7_writethrough", rd_data, row_all(13));
        check("row7_conflict", RW'(rd_conflict), 1);
        tick();
        check("row7_conflict_pulse", RW'(rd_conflict), 0);
        do_read(7, 1'b0);
        check("row7_kept", rd_data, row_all(13));

        // Read-clear of row 4 at the edge the accumulate enters S1: S1 sees zero
        do_write(4, 1'b0, 8'hFF, row_all(50));
        tick();
        set_wr(4, 1'b1, 8'hFF, row_all(5));
        do_read(4, 1'b1);
        check("row4_clear_read", rd_data, row_all(50));
        check("row4_no_conflict", RW'(rd_conflict), 0);
        tick();
        do_read(4, 1'b0);
        check("row4_after_clear", rd_data, row_all(5));
        check("row4_sum", RW'(sum_out), 40);

        // Mixed-sign lanes and the most negative row sum
        mix_row = '0;
        mix_row[0*BW +: BW] = BW'(-3);
        mix_row[1*BW +: BW] = BW'(1);
        mix_row[2*BW +: BW] = BW'(2);
        mix_row[3*BW +: BW] = BW'(3);
        mix_row[4*BW +: BW] = BW'(4);
        mix_row[5*BW +: BW] = BW'(5);
        mix_row[6*BW +: BW] = BW'(6);
        mix_row[7*BW +: BW] = BW'(-7);
        do_write(1, 1'b0, 8'hFF, mix_row);
        tick();
        do_read(1, 1'b0);
        check("row1_data", rd_data, mix_row);
        check("row1_sum", RW'(sum_out), 11);
        do_write(6, 1'b0, 8'hFF, row_all(-524288));
        tick();
        do_read(6, 1'b0);
        check("row6_sum_min", RW'(sum_out), -4194304);
        tick();
        check("row6_sum_hold", RW'(sum_out), -4194304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
